// File: rtl/ffa_pkg.sv
// Shared widths and grant encoding for the flip-flop-array request front-end.
package ffa_pkg;

    localparam int FFA_DATA_W = 8;
    localparam int FFA_ADDR_W = 3;

    typedef enum logic {
        GNT_WR = 1'b0,
        GNT_RD = 1'b1
    } ffa_grant_e;

endpackage

// File: rtl/ffa_rsp_fifo.sv
// Read-response queue: small FIFO with a combinational head, push/pop allowed together at any count.
module ffa_rsp_fifo
    import ffa_pkg::*;
#(
    parameter int DATA_W    = FFA_DATA_W,
    parameter int RSP_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          pop_data,
    output logic [$clog2(RSP_DEPTH):0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int AW = $clog2(RSP_DEPTH);

    logic [DATA_W-1:0] entry_q [RSP_DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [AW:0]       count_reg;

    // Entries are reset so the head reads as zero out of reset.
    generate
        for (genvar gi = 0; gi < RSP_DEPTH; gi++) begin : g_entry
            logic [DATA_W-1:0] entry_reg;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    entry_reg <= '0;
                end else if (push && (wr_ptr_reg == AW'(gi))) begin
                    entry_reg <= push_data;
                end
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign pop_data = entry_q[rd_ptr_reg];
    assign count    = count_reg;
    assign empty    = (count_reg == '0);
    assign full     = (count_reg == (AW+1)'(RSP_DEPTH));

endmodule

// File: rtl/ffa_req_arbiter.sv
// Serialises write/read requests onto the flip-flop array and queues read data.
// FFA_ARB_RR_EN selects round-robin arbitration; otherwise writes have fixed priority.
module ffa_req_arbiter
    import ffa_pkg::*;
#(
    parameter int DATA_W    = FFA_DATA_W,
    parameter int ADDR_W    = FFA_ADDR_W,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              wreq_valid,
    output logic              wreq_ready,
    input  logic [ADDR_W-1:0] wreq_addr,
    input  logic [DATA_W-1:0] wreq_data,

    input  logic              rreq_valid,
    output logic              rreq_ready,
    input  logic [ADDR_W-1:0] rreq_addr,

    output logic              rrsp_valid,
    input  logic              rrsp_ready,
    output logic [DATA_W-1:0] rrsp_data,

    output logic [DATA_W-1:0] arr_din,
    output logic [ADDR_W-1:0] arr_addr,
    output logic              arr_wr,
    output logic              arr_rd,
    input  logic [DATA_W-1:0] arr_dout,
    input  logic              arr_error,

    output logic              err_sticky
);

    localparam int CW = $clog2(RSP_DEPTH) + 1;

    logic [DATA_W-1:0] arr_din_reg;
    logic [ADDR_W-1:0] arr_addr_reg;
    logic              arr_wr_reg;
    logic              arr_rd_reg;     // this is the s1 stage of the read pipeline
    logic              s2_reg;
    logic              err_sticky_reg;

    logic [CW-1:0]     q_count;
    logic              q_empty;
    logic              q_full;
    logic              q_pop;
    logic [CW:0]       credit_used;
    logic              rd_elig;
    logic              grant_wr;
    logic              grant_rd;

    // Reads already issued to the array reserve a queue slot until they are pushed.
    always_comb begin
        credit_used = (CW+1)'(q_count) + (CW+1)'(arr_rd_reg) + (CW+1)'(s2_reg);
        rd_elig     = rreq_valid && !q_full && (credit_used < (CW+1)'(RSP_DEPTH));
    end

`ifdef FFA_ARB_RR_EN
    ffa_grant_e last_grant_reg;

    always_comb begin
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (wreq_valid && rd_elig) begin
            if (last_grant_reg == GNT_RD) begin
                grant_wr = 1'b1;
            end else begin
                grant_rd = 1'b1;
            end
        end else begin
            grant_wr = wreq_valid;
            grant_rd = rd_elig;
        end
    end

    // Starts as "read" so the first contended cycle favours the write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant_reg <= GNT_RD;
        end else if (grant_wr) begin
            last_grant_reg <= GNT_WR;
        end else if (grant_rd) begin
            last_grant_reg <= GNT_RD;
        end
    end
`else
    always_comb begin
        grant_wr = wreq_valid;
        grant_rd = rd_elig && !wreq_valid;
    end
`endif

    assign wreq_ready = grant_wr;
    assign rreq_ready = grant_rd;

    // Array command register; din only changes for writes so reads leave it alone.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            arr_wr_reg   <= 1'b0;
            arr_rd_reg   <= 1'b0;
            arr_addr_reg <= '0;
            arr_din_reg  <= '0;
        end else begin
            arr_wr_reg <= grant_wr;
            arr_rd_reg <= grant_rd;
            if (grant_wr) begin
                arr_addr_reg <= wreq_addr;
                arr_din_reg  <= wreq_data;
            end else if (grant_rd) begin
                arr_addr_reg <= rreq_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s2_reg         <= 1'b0;
            err_sticky_reg <= 1'b0;
        end else begin
            s2_reg <= arr_rd_reg;
            if (arr_error) begin
                err_sticky_reg <= 1'b1;
            end
        end
    end

    assign q_pop = !q_empty && rrsp_ready;

    ffa_rsp_fifo #(
        .DATA_W    (DATA_W),
        .RSP_DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (s2_reg),
        .push_data (arr_dout),
        .pop       (q_pop),
        .pop_data  (rrsp_data),
        .count     (q_count),
        .empty     (q_empty),
        .full      (q_full)
    );

    assign rrsp_valid = !q_empty;
    assign arr_din    = arr_din_reg;
    assign arr_addr   = arr_addr_reg;
    assign arr_wr     = arr_wr_reg;
    assign arr_rd     = arr_rd_reg;
    assign err_sticky = err_sticky_reg;

endmodule

// File: tb/tb_ffa_req_arbiter.sv
// Scoreboard bench for ffa_req_arbiter with a behavioural 8-entry array model on the array pins.
module tb_ffa_req_arbiter;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 3;
    localparam int RSP_DEPTH = 4;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              wreq_valid = 1'b0;
    logic              wreq_ready;
    logic [ADDR_W-1:0] wreq_addr = '0;
    logic [DATA_W-1:0] wreq_data = '0;
    logic              rreq_valid = 1'b0;
    logic              rreq_ready;
    logic [ADDR_W-1:0] rreq_addr = '0;
    logic              rrsp_valid;
    logic              rrsp_ready = 1'b0;
    logic [DATA_W-1:0] rrsp_data;
    logic [DATA_W-1:0] arr_din;
    logic [ADDR_W-1:0] arr_addr;
    logic              arr_wr;
    logic              arr_rd;
    logic [DATA_W-1:0] arr_dout = '0;
    logic              arr_error = 1'b0;
    logic              err_sticky;

    ffa_req_arbiter #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .wreq_valid (wreq_valid),
        .wreq_ready (wreq_ready),
        .wreq_addr  (wreq_addr),
        .wreq_data  (wreq_data),
        .rreq_valid (rreq_valid),
        .rreq_ready (rreq_ready),
        .rreq_addr  (rreq_addr),
        .rrsp_valid (rrsp_valid),
        .rrsp_ready (rrsp_ready),
        .rrsp_data  (rrsp_data),
        .arr_din    (arr_din),
        .arr_addr   (arr_addr),
        .arr_wr     (arr_wr),
        .arr_rd     (arr_rd),
        .arr_dout   (arr_dout),
        .arr_error  (arr_error),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Behavioural flip-flop array.
    logic [DATA_W-1:0] arr_mem [8];
    initial for (int i = 0; i < 8; i++) arr_mem[i] = '0;
    always @(posedge clk) begin
        if (arr_wr) arr_mem[arr_addr] <= arr_din;
        if (arr_rd) arr_dout <= arr_mem[arr_addr];
    end

    int checks = 0;
    int errors = 0;
    int overlap_cnt = 0;
    int rsp_total = 0;
    logic [DATA_W-1:0] model_mem [8];
    logic [DATA_W-1:0] exp_q [$];
    int rsp_cyc_q [$];

    initial for (int i = 0; i < 8; i++) model_mem[i] = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Stimulus side of the scoreboard: acceptances update the model and queue expectations.
    always @(negedge clk) begin
        if (resetn) begin
            if (wreq_valid && wreq_ready) model_mem[wreq_addr] = wreq_data;
            if (rreq_valid && rreq_ready) exp_q.push_back(model_mem[rreq_addr]);
            if (arr_wr && arr_rd) overlap_cnt++;
        end
    end

    // Monitor: compares every response the DUT hands over.
    always @(negedge clk) begin
        if (resetn && rrsp_valid && rrsp_ready) begin
            rsp_total++;
            rsp_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got 0x%0h expected no response", rrsp_data);
            end else begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                check("rsp_data", 32'(rrsp_data), 32'(e));
                $display("rsp #%0d cyc %0d data 0x%0h", rsp_total, cyc, rrsp_data);
            end
        end
    end

    task automatic apply_reset();
        resetn = 1'b0;
        wreq_valid = 1'b0;
        rreq_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("reset_state", {19'd0, arr_wr, arr_rd, arr_addr, arr_din, rrsp_valid, err_sticky},
              32'd0);
        check("reset_rrsp_data", 32'(rrsp_data), 32'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic ok;
        ok = 1'b0;
        wreq_addr = a;
        wreq_data = d;
        wreq_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (wreq_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("wr_accept", 32'(ok), 32'd1);
        @(posedge clk);
        #1 wreq_valid = 1'b0;
        $display("write addr %0d data 0x%0h", a, d);
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, output int acc_edge);
        logic ok;
        ok = 1'b0;
        acc_edge = 0;
        rreq_addr = a;
        rreq_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rreq_ready) begin
                ok = 1'b1;
                acc_edge = cyc + 1;
                break;
            end
        end
        check("rd_accept", 32'(ok), 32'd1);
        @(posedge clk);
        #1 rreq_valid = 1'b0;
        $display("read addr %0d accepted at edge %0d", a, acc_edge);
    endtask

    // Holds rreq_valid high, advancing the address on each acceptance; caller drops valid.
    task automatic run_reads(input int base, input int n, input int budget, output int got);
        got = 0;
        rreq_addr = ADDR_W'(base);
        rreq_valid = 1'b1;
        for (int c = 0; c < budget && got < n; c++) begin
            @(negedge clk);
            if (rreq_ready) got++;
            @(posedge clk);
            #1 rreq_addr = ADDR_W'(base + got);
        end
    endtask

    task automatic wait_drain(input int budget);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, lat, got, got2, base_total;
        logic seen;
        logic [1:0] g, eg;

        apply_reset();

        // Write then read the same address; response 2 cycles after acceptance.
        rrsp_ready = 1'b1;
        do_write(3'd3, 8'hA5);
        check("wr_issue", {19'd0, arr_wr, arr_rd, arr_addr, arr_din}, {19'd0, 1'b1, 1'b0, 3'd3, 8'hA5});
        do_read(3'd3, acc);
        check("rd_issue", {19'd0, arr_wr, arr_rd, arr_addr, arr_din}, {19'd0, 1'b0, 1'b1, 3'd3, 8'hA5});
        seen = 1'b0;
        lat = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rrsp_valid) begin
                seen = 1'b1;
                lat = cyc - acc;
                break;
            end
        end
        check("rsp_seen", 32'(seen), 32'd1);
        check("rsp_latency", 32'(lat), 32'd2);
        wait_drain(10);

        // Fill addr*0x11, then read 0..7 back-to-back.
        for (int a = 0; a < 8; a++) do_write(ADDR_W'(a), DATA_W'(a * 8'h11));
        rsp_cyc_q.delete();
        run_reads(0, 8, 8, got);
        rreq_valid = 1'b0;
        check("b2b_accepts", 32'(got), 32'd8);
        wait_drain(20);
        check("b2b_rsp_count", 32'(rsp_cyc_q.size()), 32'd8);
        if (rsp_cyc_q.size() == 8) check("b2b_rsp_span", 32'(rsp_cyc_q[7] - rsp_cyc_q[0]), 32'd7);

        // Credit limit with a stalled consumer.
        rrsp_ready = 1'b0;
        base_total = rsp_total;
        run_reads(0, 6, 10, got);
        check("credit_accepts", 32'(got), 32'd4);
        @(negedge clk);
        check("credit_rreq_ready", 32'(rreq_ready), 32'd0);
        @(posedge clk);
        #1 rrsp_ready = 1'b1;
        run_reads(4, 2, 20, got2);
        rreq_valid = 1'b0;
        check("credit_rest_accepts", 32'(got2), 32'd2);
        wait_drain(20);
        check("credit_rsp_count", 32'(rsp_total - base_total), 32'd6);

        // Contention for 8 cycles straight after reset.
        apply_reset();
        rrsp_ready = 1'b1;
        wreq_addr = 3'd5;
        wreq_data = 8'h3C;
        rreq_addr = 3'd5;
        wreq_valid = 1'b1;
        rreq_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            g = {wreq_ready, rreq_ready};
`ifdef FFA_ARB_RR_EN
            eg = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
            eg = 2'b10;
`endif
            check($sformatf("grant[%0d]", i), 32'(g), 32'(eg));
            $display("contend cycle %0d grant %s", i, g == 2'b10 ? "W" : (g == 2'b01 ? "R" : "-"));
            @(posedge clk);
            #1;
        end
        wreq_valid = 1'b0;
        rreq_valid = 1'b0;
        wait_drain(20);

        // Reset while a response is queued and two reads are in flight.
        rrsp_ready = 1'b0;
        run_reads(1, 3, 10, got);
        check("inflight_accepts", 32'(got), 32'd3);
        check("inflight_state", {29'd0, rrsp_valid, arr_rd, dut.s2_reg}, 32'd7);
        rreq_valid = 1'b0;
        resetn = 1'b0;
        exp_q.delete();
        #1;
        check("async_reset_rrsp_valid", {30'd0, rrsp_valid, arr_rd}, 32'd0);
        @(posedge clk);
        #1 resetn = 1'b1;
        rrsp_ready = 1'b1;
        base_total = rsp_total;
        repeat (8) @(negedge clk);
        check("no_stale_rsp", 32'(rsp_total - base_total), 32'd0);

        // Sticky error.
        @(posedge clk);
        #1 arr_error = 1'b1;
        @(posedge clk);
        #1 arr_error = 1'b0;
        @(negedge clk);
        check("err_sticky_set", 32'(err_sticky), 32'd1);
        repeat (5) @(negedge clk);
        check("err_sticky_hold", 32'(err_sticky), 32'd1);
        apply_reset();
        @(negedge clk);
        check("err_sticky_cleared", 32'(err_sticky), 32'd0);

        check("no_wr_rd_overlap", 32'(overlap_cnt), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ffa_req_arbiter.md
# ffa_req_arbiter

Request front-end for the 8-entry flip-flop array. It accepts independent write and read request streams over valid/ready handshakes and serialises them so the array never sees `wr` and `rd` in the same cycle. It tracks read latency and returns read data through a backpressured response queue. It sits directly upstream of the array, drives its `din/addr/wr/rd` pins, and consumes its `dout/error` pins.

## Interface
Parameters:
- `DATA_W`, default 8: data width; must match the array.
- `ADDR_W`, default 3: address width; must match the array.
- `RSP_DEPTH`, default 4: response queue entries; power of two, ≥2.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` in 1: clock.
  - `resetn` in 1: asynchronous active-low reset.
- Write request port:
  - `wreq_valid` in 1: write request.
  - `wreq_ready` out 1: write accepted this cycle.
  - `wreq_addr` in ADDR_W: write address.
  - `wreq_data` in DATA_W: write data.
- Read request port:
  - `rreq_valid` in 1: read request.
  - `rreq_ready` out 1: read accepted this cycle.
  - `rreq_addr` in ADDR_W: read address.
- Read response port:
  - `rrsp_valid` out 1: response available.
  - `rrsp_ready` in 1: consumer takes response.
  - `rrsp_data` out DATA_W: read data, head of queue.
- Array side:
  - `arr_din` out DATA_W: to array `din`.
  - `arr_addr` out ADDR_W: to array `addr`.
  - `arr_wr` out 1: to array `wr`.
  - `arr_rd` out 1: to array `rd`.
  - `arr_dout` in DATA_W: from array `dout`.
  - `arr_error` in 1: from array `error`.
- Status:
  - `err_sticky` out 1: set when `arr_error` is sampled high; cleared only by reset.

## Operation
- A request is accepted at a rising edge where valid && ready. At most one request is accepted per cycle.
- `wreq_ready` and `rreq_ready` are never both 1. They depend combinationally on the valids, the credit, and the arbitration pointer.
- Read eligibility: `rreq_valid` && (`q_count` + `inflight`) < RSP_DEPTH.
  - `inflight` is the number of accepted reads not yet pushed into the queue (0..2).
- Arbitration (`FFA_ARB_RR_EN` defined):
  - Round-robin via a `last_grant` bit.
  - If both a write and an eligible read are pending, grant the one not granted last.
  - A lone eligible requester is always granted.
  - `last_grant` updates only on acceptance.
- On acceptance, these are registered from the accepted request:
  - `arr_wr` or `arr_rd` = 1, the other = 0.
  - `arr_addr`.
  - `arr_din` is taken from `wreq_data` for writes and holds its value for reads.
- With no acceptance, `arr_wr` = `arr_rd` = 0, and `arr_addr`/`arr_din` hold their values.
- Read pipeline: flag `s1` = `arr_rd`; `s2` is `s1` delayed one cycle. At an edge with `s2` = 1, `arr_dout` is pushed into the response queue.
- Response queue: FIFO, pop on `rrsp_valid` && `rrsp_ready`.
  - Push and pop in the same cycle are legal, at any count.
  - Overflow is impossible by the credit rule.
- Ordering: the array sees operations in acceptance order. A read accepted after a write to the same address returns the new data.

## Timing
- Reset values:
  - `arr_wr` = `arr_rd` = 0, `arr_din` = 0, `arr_addr` = 0.
  - `s1` = `s2` = 0, queue empty, `rrsp_valid` = 0, `rrsp_data` = 0.
  - `err_sticky` = 0, `last_grant` = read, so the first contended cycle grants the write.
- Write: accepted at edge E0, `arr_wr` high for one cycle after E0, and the array updates at E1.
- Read: accepted at E0, `arr_rd` high for the cycle after E0, and the array registers `dout` at E1. The queue push happens at E2, so `rrsp_valid` rises after E2.
  - This is 2 cycles minimum from acceptance to response.
- Back-to-back reads sustain 1/cycle while credit allows.
- Reset mid-operation clears all state asynchronously; in-flight reads and queued data are discarded.

## Configuration
- `FFA_ARB_RR_EN` defined: round-robin arbitration as above.
- `FFA_ARB_RR_EN` undefined: fixed priority, with write always over read. The `last_grant` register is not built, and reads can starve under continuous writes.

## Structure
- Package `ffa_pkg`:
  - `FFA_DATA_W` = 8 and `FFA_ADDR_W` = 3.
  - Enum `ffa_grant_e` {GNT_WR, GNT_RD}.
- Sub-module `ffa_rsp_fifo`:
  - Parameterised by DATA_W and RSP_DEPTH.
  - Provides push/pop, `count`, `empty`, and `full`.
- Arbitration, the credit check, and the `s1`/`s2` pipeline stay in the top module.

## Test plan
- Write 0xA5 to addr 3, then read addr 3 with `rrsp_ready` = 1 → `rrsp_valid` rises 2 cycles after read acceptance with `rrsp_data` = 0xA5, and `arr_wr`/`arr_rd` are never simultaneously 1.
- Both ports valid every cycle for 8 cycles (RR) → grants alternate W,R,W,R…, starting with W after reset.
- `rrsp_ready` = 0 and 6 reads requested → exactly 4 accepted, then `rreq_ready` = 0. Releasing `rrsp_ready` drains 4 responses in order and accepts the remaining 2.
- Reads to addrs 0..7 back-to-back after writing data = addr×0x11 → responses 0x00,0x11,…,0x77 at 1/cycle.
- Assert `resetn` = 0 while 2 reads are in flight → `rrsp_valid` drops immediately, and no stale response appears after release.
- Force `arr_error` = 1 for one cycle → `err_sticky` = 1 and it holds until reset.
